// File: rtl/mul_seqn_if.sv
// Handshake and operand/result bundle for the sequential multiplier.
// The requester uses the master modport; the multiplier uses the slave modport.
interface mul_seqn_if #(
  parameter int unsigned N = 32
);

  localparam int unsigned PW = 2 * N;

  logic          start;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          busy;
  logic          done;
  logic [PW-1:0] product;

  // Requester side: issues operands, observes status and result
  modport master (
    output start,
    output a,
    output b,
    input  busy,
    input  done,
    input  product
  );

  // Multiplier side: consumes operands, drives status and result
  modport slave (
    input  start,
    input  a,
    input  b,
    output busy,
    output done,
    output product
  );

endinterface

// File: rtl/mul_seqn.sv
// Sequential N-bit shift-and-add multiplier with a start/done handshake.
// One multiplier bit is consumed per cycle; an op takes N RUN cycles plus a
// one-cycle DONE state, so back-to-back ops are spaced N+2 cycles apart.
// Build option: define MUL_SEQN_SIGNED_EN to treat a/b as two's complement
// (magnitudes are multiplied and the sign is applied when the result is stored).
module mul_seqn #(
  parameter int unsigned N = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  mul_seqn_if.slave   bus
);

  localparam int unsigned PW = 2 * N;
  localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state;
  logic [PW-1:0] mcand;
  logic [N-1:0]  mplier;
  logic [PW-1:0] acc;
  logic [CW-1:0] cnt;
  logic          busy_q;
  logic          done_q;
  logic [PW-1:0] product_q;

  logic [N-1:0]  a_in;
  logic [N-1:0]  b_in;
  logic [PW-1:0] acc_next;
  logic [PW-1:0] result;
  logic          last_step;

`ifdef MUL_SEQN_SIGNED_EN
  logic          sign;
  logic          sign_in;
`endif

  // Operand conditioning at accept: magnitudes in signed builds, raw otherwise
  always_comb begin
    a_in = bus.a;
    b_in = bus.b;
`ifdef MUL_SEQN_SIGNED_EN
    sign_in = bus.a[N-1] ^ bus.b[N-1];
    if (bus.a[N-1]) a_in = N'(0) - bus.a;
    if (bus.b[N-1]) b_in = N'(0) - bus.b;
`endif
  end

  // Partial-product accumulate and final result formation
  always_comb begin
    acc_next  = acc;
    if (mplier[0]) acc_next = acc + mcand;
    result    = acc_next;
`ifdef MUL_SEQN_SIGNED_EN
    if (sign) result = PW'(0) - acc_next;
`endif
    last_step = (cnt == CW'(N - 1));
  end

  // Control FSM and datapath registers; product only updates on DONE entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
`ifdef MUL_SEQN_SIGNED_EN
      sign      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= PW'(a_in);
            mplier <= b_in;
            acc    <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
`ifdef MUL_SEQN_SIGNED_EN
            sign   <= sign_in;
`endif
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= {mcand[PW-2:0], 1'b0};
          mplier <= {1'b0, mplier[N-1:1]};
          cnt    <= cnt + CW'(1);
          if (last_step) begin
            product_q <= result;
            done_q    <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

// File: tb/tb_mul_seqn.sv
// Self-checking bench for mul_seqn at N=8 (unsigned by default, signed when
// MUL_SEQN_SIGNED_EN is defined). Expected products come from plain integer
// multiplication of the operands.
`timescale 1ns/1ps
module tb_mul_seqn;

  localparam int unsigned N   = 8;
  localparam int unsigned LAT = N;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;

  mul_seqn_if #(.N(N)) bus ();

  mul_seqn #(.N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product from integer arithmetic
  function automatic logic [15:0] ref_prod(input logic [7:0] x, input logic [7:0] y);
    int sx;
    int sy;
`ifdef MUL_SEQN_SIGNED_EN
    sx = int'($signed(x));
    sy = int'($signed(y));
`else
    sx = int'(x);
    sy = int'(y);
`endif
    return 16'(sx * sy);
  endfunction

  // Present operands with start for one accepting edge
  task automatic issue(input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Count edges after the accept edge until done is seen (-1 on timeout)
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.done === 1'b1) return;
    end
    lat = -1;
  endtask

  // Run one op and check latency, product and the post-done cycle
  task automatic run_check(input string name, input logic [7:0] av,
                           input logic [7:0] bv, input logic [15:0] exp_p);
    int lat;
    issue(av, bv);
    wait_done(lat);
    vectors++;
    if (lat !== int'(LAT)) begin
      miscompares++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, LAT);
    end
    vectors++;
    if (bus.product !== exp_p) begin
      miscompares++;
      $display("FAIL %s product: a=%0h b=%0h got %h expected %h", name, av, bv, bus.product, exp_p);
    end
    @(negedge clk);
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s after_done: done=%b busy=%b expected 0 0", name, bus.done, bus.busy);
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b done=%b product=%h expected 0 0 0000",
               bus.busy, bus.done, bus.product);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
`ifdef MUL_SEQN_SIGNED_EN
    run_check("s_m3x5",      8'hFD, 8'h05, 16'hFFF1);
    run_check("s_m128xm128", 8'h80, 8'h80, 16'h4000);
    run_check("s_m128x1",    8'h80, 8'h01, 16'hFF80);
    run_check("s_13x11",     8'd13, 8'd11, 16'h008F);
    run_check("s_0x200",     8'd0,  8'd200, 16'h0000);
`else
    run_check("u_13x11",   8'd13,  8'd11,  16'h008F);
    run_check("u_255x255", 8'd255, 8'd255, 16'hFE01);
    run_check("u_0x200",   8'd0,   8'd200, 16'h0000);
`endif
  endtask

  task automatic test_busy_flags();
    issue(8'd7, 8'd9);
    @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL run_flags: busy=%b done=%b expected 1 0", bus.busy, bus.done);
    end
    vectors++;
    if (bus.product !== 16'h0000) begin
      miscompares++;
      $display("FAIL product_hold_run: got %h expected 0000", bus.product);
    end
    repeat (LAT + 2) @(negedge clk);
    vectors++;
    if (bus.product !== ref_prod(8'd7, 8'd9)) begin
      miscompares++;
      $display("FAIL product_hold_idle: got %h expected %h", bus.product, ref_prod(8'd7, 8'd9));
    end
  endtask

  task automatic test_midrun_reset();
    int pulses;
    issue(8'd13, 8'd11);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 16'h0) begin
      miscompares++;
      $display("FAIL midrun_reset: busy=%b done=%b product=%h expected 0 0 0000",
               bus.busy, bus.done, bus.product);
    end
    @(negedge clk);
    reset_n = 1'b1;
    pulses  = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL midrun_reset_nodone: got %0d pulses expected 0", pulses);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    int pulses;
    issue(8'd13, 8'd11);
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd1;
    bus.b     = 8'd1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat);
    vectors++;
    if (lat !== int'(LAT) - 3) begin
      miscompares++;
      $display("FAIL ignore_latency: got %0d expected %0d", lat, LAT - 3);
    end
    vectors++;
    if (bus.product !== ref_prod(8'd13, 8'd11)) begin
      miscompares++;
      $display("FAIL ignore_product: got %h expected %h", bus.product, ref_prod(8'd13, 8'd11));
    end
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL ignore_extra_done: got %0d pulses expected 0", pulses);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int gap;
    int holds_bad;
    logic [15:0] p1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd3;
    bus.b     = 8'd4;
    @(posedge clk);
    #1;
    bus.a = 8'd5;
    bus.b = 8'd6;
    wait_done(lat);
    vectors++;
    if (lat !== int'(LAT)) begin
      miscompares++;
      $display("FAIL b2b_latency: got %0d expected %0d", lat, LAT);
    end
    p1 = ref_prod(8'd3, 8'd4);
    vectors++;
    if (bus.product !== p1) begin
      miscompares++;
      $display("FAIL b2b_first: got %h expected %h", bus.product, p1);
    end
    gap       = 0;
    holds_bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      gap++;
      if (gap == 2) begin
        #1;
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.done === 1'b1) break;
      if (bus.product !== p1) holds_bad++;
    end
    vectors++;
    if (gap !== int'(LAT) + 2) begin
      miscompares++;
      $display("FAIL b2b_gap: got %0d expected %0d", gap, LAT + 2);
    end
    vectors++;
    if (holds_bad !== 0) begin
      miscompares++;
      $display("FAIL b2b_hold: got %0d changed cycles expected 0", holds_bad);
    end
    vectors++;
    if (bus.product !== ref_prod(8'd5, 8'd6)) begin
      miscompares++;
      $display("FAIL b2b_second: got %h expected %h", bus.product, ref_prod(8'd5, 8'd6));
    end
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    logic [7:0] ra;
    logic [7:0] rb;
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (i == 0) ra = 8'h80;
      if (i == 1) rb = 8'hFF;
      if (i == 2) begin ra = 8'h7F; rb = 8'h80; end
      run_check("random", ra, rb, ref_prod(ra, rb));
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_directed();
    test_busy_flags();
    test_midrun_reset();
    test_ignore_start();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
